// File: rtl/ddr3_wdata_pack.sv
// Packs 16-bit pixels into 128-bit MIG write words and buffers them in a FWFT FIFO; a word is visible the cycle after its 8th pixel.
// No backpressure to the pixel source: a completed word is dropped (sticky overflow) when full; pops on empty set sticky underflow.
module ddr3_wdata_pack #(
  parameter int PIX_W  = 16,
  parameter int WORD_W = 128,
  parameter int DEPTH  = 1024
) (
  input  logic                     ui_clk,
  input  logic                     ui_clk_sync_rst,
  input  logic                     init_calib_complete,
  input  logic                     wr_load,
  input  logic                     din_en,
  input  logic [PIX_W-1:0]         din,
  input  logic                     app_wdf_wren,
  output logic [WORD_W-1:0]        app_wdf_data,
  output logic [$clog2(DEPTH):0]   wfifo_rcount,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int NPIX = WORD_W / PIX_W;
  localparam int PCW  = $clog2(NPIX);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;

  logic                          load_d0_q, load_d1_q;
  logic [PCW-1:0]                pack_cnt_q, pack_cnt_d;
  logic [NPIX-1:0][PIX_W-1:0]    pack_q, pack_d, pack_nxt;
  logic [AW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [WORD_W-1:0]             data_q, data_d;
  logic                          ovf_q, ovf_d, unf_q, unf_d;
  logic [WORD_W-1:0]             mem_q [DEPTH];

  logic frame_start, accept, pop_req, push_req, empty, full, last, do_pop, do_push;

  always_comb begin
    frame_start = load_d0_q & ~load_d1_q;
    accept      = din_en & init_calib_complete & ~frame_start;
    pop_req     = app_wdf_wren & ~frame_start;
    empty       = (count_q == '0);
    full        = (count_q == CW'(DEPTH));
    last        = (pack_cnt_q == PCW'(NPIX - 1));
    push_req    = accept & last;
    do_pop      = pop_req & ~empty;
    // A pop on a full buffer frees the slot the simultaneous push needs.
    do_push     = push_req & (~full | do_pop);
  end

  // pack_d carries the current pixel so the 8th pixel lands in the pushed word.
  always_comb begin
    pack_d = pack_q;
    if (accept) pack_d[pack_cnt_q] = din;
  end

  always_comb begin
    pack_cnt_d = pack_cnt_q;
    pack_nxt   = pack_d;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_d     = data_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    if (accept) pack_cnt_d = pack_cnt_q + PCW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_req & full & ~do_pop) ovf_d = 1'b1;
    if (pop_req & empty) unf_d = 1'b1;

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Registered head: follow the next entry, bypassing the word being written when it becomes head.
    if (do_pop) begin
      if (count_q != CW'(1)) data_d = mem_q[rd_ptr_q + AW'(1)];
      else if (do_push)      data_d = pack_d;
    end else if (empty && do_push) begin
      data_d = pack_d;
    end

    if (frame_start) begin
      pack_cnt_d = '0;
      pack_nxt   = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      load_d0_q  <= 1'b0;
      load_d1_q  <= 1'b0;
      pack_cnt_q <= '0;
      pack_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_q     <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      load_d0_q  <= wr_load;
      load_d1_q  <= load_d0_q;
      pack_cnt_q <= pack_cnt_d;
      pack_q     <= pack_nxt;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (do_push && !ui_clk_sync_rst) mem_q[wr_ptr_q] <= pack_d;
  end

  assign app_wdf_data = data_q;
  assign wfifo_rcount = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: doc/ddr3_wdata_pack.md
Name: ddr3_wdata_pack

Overview:
- Write-side data stage in the ui_clk domain, directly upstream of the DDR3 read/write controller.
- Packs a stream of 16-bit pixels into 128-bit MIG write words and buffers them in a first-word-fall-through word FIFO.
- Reports buffered word count to the controller as wfifo_rcount and pops one word per app_wdf_wren.
- Drives app_wdf_data to the MIG core.

Parameters:
- PIX_W, 16, input pixel width.
- WORD_W, 128, MIG write word width; WORD_W/PIX_W = 8 pixels per word.
- DEPTH, 1024, buffer depth in words; power of two; count width 11.

Ports:
- ui_clk  input  1  MIG user clock; the only clock.
- ui_clk_sync_rst  input  1  reset, synchronous to ui_clk, active-high.
- init_calib_complete  input  1  DDR3 calibration done; pixels ignored while low.
- wr_load  input  1  source frame-start level, asynchronous origin.
- din_en  input  1  pixel valid.
- din  input  16  pixel data.
- app_wdf_wren  input  1  pop strobe from controller; one word consumed per high cycle.
- app_wdf_data  output  128  head word to MIG.
- wfifo_rcount  output  11  complete words currently buffered, 0..1024.
- overflow  output  1  sticky: a completed word was dropped because the buffer was full.
- underflow  output  1  sticky: pop requested while the buffer was empty.

Behaviour:
- Reset (ui_clk_sync_rst high at a posedge):
  - pack_cnt=0, packing register=0, pointers=0.
  - wfifo_rcount=0, app_wdf_data=0, overflow=0, underflow=0.
  - Sync flops=0.
  - Reset mid-frame discards all partial and buffered data.
- wr_load goes through a 2-flop synchronizer (d0, d1). frame_start = d0 & ~d1, a one-cycle pulse.
- Packing:
  - An accepted pixel requires din_en & init_calib_complete.
  - Pixel k (pack_cnt=k, 0..7) lands in bits [16k+15:16k]; the first pixel goes to the LSBs.
  - pack_cnt increments modulo 8.
  - On acceptance with pack_cnt=7, the completed word (including the current pixel) is pushed.
- Push timing: 8th pixel accepted in cycle N -> word written at posedge ending N; wfifo_rcount increments and the word is visible in cycle N+1.
- FIFO:
  - First-word-fall-through. app_wdf_data shows the head word whenever wfifo_rcount>0, and holds its last value when empty.
  - On app_wdf_wren with wfifo_rcount>0, the head pops; the next word appears in the following cycle.
  - wfifo_rcount is updated in the same cycle as the pointer movement.
- Push and pop in the same cycle:
  - When 0<count<DEPTH, both occur and the count is unchanged.
  - When count=DEPTH, the pop frees a slot first, so the push is accepted with no overflow.
  - When count=0, the pop is ignored and underflow is set; the push is accepted and the count becomes 1.
- Full: a push with count=DEPTH and no pop drops the word and sets overflow; pack_cnt still wraps to 0.
- Empty: app_wdf_wren with count=0 does not move pointers and sets underflow.
- Pointers are log2(DEPTH) bits and wrap naturally. Count saturates within 0..DEPTH by the rules above.
- frame_start, highest priority after reset:
  - Next cycle: pack_cnt=0, partial word discarded, pointers=0, wfifo_rcount=0, overflow and underflow cleared.
  - A pixel or pop in the frame_start cycle is discarded.
  - The controller detects the same edge through an equal-depth sync, so both sides realign at frame start.
- init_calib_complete low: no packing occurs; pops are still honoured.
- Sticky flags clear only on reset or frame_start.

Test Plan:
- Reset, calib=1, send 8 pixels 0x0001..0x0008 back-to-back -> cycle after the 8th: wfifo_rcount=1, app_wdf_data=0x0008_0007_0006_0005_0004_0003_0002_0001; pulse app_wdf_wren -> wfifo_rcount=0.
- Stream 64 pixels with no pops -> wfifo_rcount=8; then hold app_wdf_wren and keep streaming 1 pixel/cycle -> words pop in order, count drops by 1 per cycle except on push cycles where it holds.
- Fill 1024 words, push one more -> wfifo_rcount=1024, overflow=1, head word unchanged; next push with simultaneous pop -> accepted, count stays 1024, no new drop.
- app_wdf_wren with empty buffer -> underflow=1, wfifo_rcount=0; toggle wr_load 0->1 -> 3 cycles later underflow=0.
- Push 5 pixels plus 3 words, raise wr_load -> after frame_start, wfifo_rcount=0, pack_cnt=0; the next 8 pixels form a word with the first new pixel in bits[15:0].
- calib=0 with 16 din_en pulses -> wfifo_rcount stays 0; assert ui_clk_sync_rst mid-stream -> all outputs 0 on the next posedge.
